// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multicycle multiply/divide sequencer and HI/LO owner.
// Runs 32-step shift-add multiply and restoring divide, stalls EX.
//
// Ports:
//   clk    in   core clock, all state on rising edge
//   rst    in   synchronous active-high reset
//   start  in   valid HI/LO-class instruction in EX
//   op     in   000 mult 001 multu 010 div 011 divu 100 mthi 101 mtlo
//   src_a  in   rs: dividend / multiplicand / mthi-mtlo data
//   src_b  in   rt: divisor / multiplier
//   flush  in   cancel in-flight operation
//   stall  out  freeze IF/ID/EX (combinational)
//   hi     out  HI register
//   lo     out  LO register
//   busy   out  high while iterating
//
// Optional feature: define MULDIV_FAST_MUL_EN to compute mult/multu
// combinationally in one cycle; divide always stays iterative.

module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // op decode
    logic is_mul;
    logic is_div;
    logic is_mthi;
    logic is_mtlo;
    logic is_multi;
    logic accept;

    assign is_mul  = (op[2:1] == 2'b00);
    assign is_div  = (op[2:1] == 2'b01);
    assign is_mthi = (op == 3'b100);
    assign is_mtlo = (op == 3'b101);

`ifdef MULDIV_FAST_MUL_EN
    assign is_multi = is_div;
`else
    assign is_multi = is_mul | is_div;
`endif

    assign accept = (state == S_IDLE) & start & ~flush;

    // operand magnitudes; op[0]=0 selects the signed variants
    logic        sgn;
    logic        sa;
    logic        sb;
    logic [31:0] amag;
    logic [31:0] bmag;

    assign sgn  = ~op[0];
    assign sa   = sgn & src_a[31];
    assign sb   = sgn & src_b[31];
    assign amag = sa ? (~src_a + 32'd1) : src_a;
    assign bmag = sb ? (~src_b + 32'd1) : src_b;

`ifdef MULDIV_FAST_MUL_EN
    // sign-extend for signed ops; low 64 bits of the product are exact
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] fast_prod;

    assign ext_a     = {{32{sa}}, src_a};
    assign ext_b     = {{32{sb}}, src_b};
    assign fast_prod = ext_a * ext_b;
`endif

    // iteration state
    // mul: acc = {partial product, multiplier shifting out}
    // div: acc = {remainder, dividend shifting out / quotient in}
    logic [63:0] acc;
    logic [63:0] acc_nx;
    logic [31:0] opd;
    logic [4:0]  cnt;
    logic        div_r;
    logic        neg_lo;
    logic        neg_hi;
    logic        dz;
    logic [31:0] a_raw;
    logic        cnt_last;

    assign cnt_last = (cnt == 5'd31);

    logic [32:0] mul_sum;
    logic [32:0] div_tmp;
    logic [32:0] div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
        div_tmp  = {acc[63:32], acc[31]};
        div_diff = div_tmp - {1'b0, opd};
        acc_nx   = {mul_sum, acc[31:1]};
        if (div_r) begin
            // borrow out means the trial subtract failed: restore
            if (div_diff[32])
                acc_nx = {div_tmp[31:0], acc[30:0], 1'b0};
            else
                acc_nx = {div_diff[31:0], acc[30:0], 1'b1};
        end
    end

    // sign correction of the final step's value
    logic [63:0] prod_fix;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [63:0] res;

    always_comb begin
        prod_fix = neg_lo ? (~acc_nx + 64'd1) : acc_nx;
        q_fix    = neg_lo ? (~acc_nx[31:0] + 32'd1) : acc_nx[31:0];
        r_fix    = neg_hi ? (~acc_nx[63:32] + 32'd1) : acc_nx[63:32];
        res      = prod_fix;
        if (div_r) begin
            if (dz)
                res = {a_raw, 32'hFFFF_FFFF};
            else
                res = {r_fix, q_fix};
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // next state
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept & is_multi)
                    state_nx = S_BUSY;
            end
            S_BUSY: begin
                if (flush)
                    state_nx = S_IDLE;
                else if (cnt_last)
                    state_nx = S_DONE;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        stall = 1'b0;
        busy  = 1'b0;
        unique case (state)
            S_IDLE: stall = start & ~flush & is_multi;
            S_BUSY: begin
                stall = ~flush;
                busy  = 1'b1;
            end
            default: begin
                stall = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

    // datapath and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            opd    <= 32'd0;
            div_r  <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dz     <= 1'b0;
            a_raw  <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            is_div: begin
                                cnt    <= 5'd0;
                                acc    <= {32'd0, amag};
                                opd    <= bmag;
                                div_r  <= 1'b1;
                                neg_lo <= sa ^ sb;
                                neg_hi <= sa;
                                dz     <= (src_b == 32'd0);
                                a_raw  <= src_a;
                            end
                            is_mul: begin
`ifdef MULDIV_FAST_MUL_EN
                                hi <= fast_prod[63:32];
                                lo <= fast_prod[31:0];
`else
                                cnt    <= 5'd0;
                                acc    <= {32'd0, bmag};
                                opd    <= amag;
                                div_r  <= 1'b0;
                                neg_lo <= sa ^ sb;
                                neg_hi <= sa ^ sb;
                                dz     <= 1'b0;
                                a_raw  <= src_a;
`endif
                            end
                            is_mthi: hi <= src_a;
                            is_mtlo: lo <= src_a;
                            default: begin
                                hi <= hi;
                                lo <= lo;
                            end
                        endcase
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        cnt <= 5'd0;
                    end else begin
                        acc <= acc_nx;
                        cnt <= cnt + 5'd1;
                        if (cnt_last) begin
                            hi <= res[63:32];
                            lo <= res[31:0];
                        end
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed bench for muldiv_ctrl with an arithmetic
// reference model checked every cycle plus literal expectations.

module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int checks = 0;
    int failures = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int MUL_STALL = FAST ? 0 : 33;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .stall (stall),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit multi(input logic [2:0] o);
        return (o == 3'd2) || (o == 3'd3) ||
               (!FAST && ((o == 3'd0) || (o == 3'd1)));
    endfunction

    // returns {hi, lo}
    function automatic logic [63:0] ref_res(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] pa;
        logic signed [63:0] pb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        pa = {{32{a[31]}}, a};
        pb = {{32{b[31]}}, b};
        case (o)
            3'd0: return pa * pb;
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                q = pa / pb;
                r = pa % pb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // m_left: 0 idle, >0 busy cycles left, -1 result-ready cycle
    int          m_left = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("stall", stall,
                (m_left == 0 && start && !flush && multi(op)) ||
                (m_left > 0 && !flush));
            chk("busy", busy, m_left > 0);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
        if (rst) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_hi    = 32'd0;
            m_lo    = 32'd0;
        end else if (m_left == 0) begin
            if (start && !flush) begin
                if (multi(op)) begin
                    m_left = 32;
                    m_pend = ref_res(op, src_a, src_b);
                end else if (op == 3'd0 || op == 3'd1) begin
                    {m_hi, m_lo} = ref_res(op, src_a, src_b);
                end else if (op == 3'd4) begin
                    m_hi = src_a;
                end else if (op == 3'd5) begin
                    m_lo = src_a;
                end
            end
        end else if (m_left > 0) begin
            if (flush) begin
                m_left = 0;
            end else if (m_left == 1) begin
                {m_hi, m_lo} = m_pend;
                m_left = -1;
            end else begin
                m_left = m_left - 1;
            end
        end else begin
            m_left = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // hold the instruction until the first non-stalled cycle
    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int ns,
                          output int nb);
        bit done;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        ns    = 0;
        nb    = 0;
        done  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (stall) begin
                ns++;
            end else begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout: stall still %b after 100 cycles", stall);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic op_chk(input string nm, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int es);
        int ns;
        int nb;
        run_op(o, a, b, ns, nb);
        chk({nm, "_stalls"}, ns, es);
        chk({nm, "_busys"}, nb, (es == 0) ? 0 : 32);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ns;
        int nb;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", busy, 1'b0);

        op_chk("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        op_chk("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        op_chk("mult", 3'd0, 32'hFFFF_FFFF, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALL);
        op_chk("multu", 3'd1, 32'hFFFF_FFFF, 32'd2,
               32'd1, 32'hFFFF_FFFE, MUL_STALL);
        op_chk("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 33);
        op_chk("divu_5_0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33);
        op_chk("div_m5_0", 3'd2, 32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, 33);
        op_chk("div_m100_m7", 3'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
               32'hFFFF_FFFE, 32'd14, 33);

        vecs[0] = '{3'd0, 32'h1234_5678, 32'h9ABC_DEF0};
        vecs[1] = '{3'd1, 32'h1234_5678, 32'h9ABC_DEF0};
        vecs[2] = '{3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010};
        vecs[4] = '{3'd0, 32'h8000_0000, 32'h8000_0000};
        vecs[5] = '{3'd1, 32'h8000_0000, 32'h8000_0000};
        vecs[6] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[7] = '{3'd3, 32'h0000_0003, 32'hFFFF_FFFF};
        foreach (vecs[i])
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, ns, nb);

        // mthi/mtlo back-to-back, then no-op encodings
        run_op(3'd4, 32'hA5A5_A5A5, 32'd0, ns, nb);
        chk("mthi_stalls", ns, 0);
        chk("mthi_hi", hi, 32'hA5A5_A5A5);
        run_op(3'd5, 32'h5A5A_5A5A, 32'd0, ns, nb);
        chk("mtlo_stalls", ns, 0);
        chk("mtlo_lo", lo, 32'h5A5A_5A5A);
        chk("mtlo_hi_kept", hi, 32'hA5A5_A5A5);
        run_op(3'd7, 32'h1111_1111, 32'h2222_2222, ns, nb);
        run_op(3'd6, 32'h3333_3333, 32'h4444_4444, ns, nb);
        chk("nop_stalls", ns, 0);
        chk("nop_hi", hi, 32'hA5A5_A5A5);
        chk("nop_lo", lo, 32'h5A5A_5A5A);

        // flush in IDLE drops the start
        start = 1'b1;
        op    = 3'd4;
        src_a = 32'hDEAD_BEEF;
        flush = 1'b1;
        tick;
        start = 1'b0;
        flush = 1'b0;
        chk("idle_flush_hi", hi, 32'hA5A5_A5A5);

        // flush mid-divide at cycle 20
        run_op(3'd4, 32'h1234, 32'd0, ns, nb);
        run_op(3'd5, 32'h1234, 32'd0, ns, nb);
        start = 1'b1;
        op    = 3'd3;
        src_a = 32'd100;
        src_b = 32'd7;
        for (int i = 0; i < 20; i++) tick;
        flush = 1'b1;
        tick;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", stall, 1'b0);
        chk("flush_busy", busy, 1'b0);
        chk("flush_hi", hi, 32'h1234);
        chk("flush_lo", lo, 32'h1234);
        tick;

        // reset mid-divide at cycle 10
        start = 1'b1;
        op    = 3'd3;
        src_a = 32'd100;
        src_b = 32'd7;
        for (int i = 0; i < 10; i++) tick;
        rst   = 1'b1;
        start = 1'b0;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_stall", stall, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        tick;

        op_chk("divu_after_rst", 3'd3, 32'd1000, 32'd10,
               32'd0, 32'd100, 33);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multicycle multiply/divide sequencer and HI/LO register owner for the 5-stage MIPS core. Receives mult/multu/div/divu/mthi/mtlo from the EX stage, runs iterative 32-step shift-add multiply and restoring divide, and stalls the pipeline until the result is committed to HI/LO. It also handles cancellation on exception flush. It drives HI/LO to the mfhi/mflo datapath path.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX stage holds a valid HI/LO-class instruction; held stable by pipeline while stall=1.
- op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 treated as no-op.
- src_a  in  32  rs value (dividend / multiplicand / mthi/mtlo data).
- src_b  in  32  rt value (divisor / multiplier).
- flush  in  1  exception/eret flush of EX; cancels any in-flight operation.
- stall  out  1  freeze IF/ID/EX; combinational.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  state==BUSY (debug/perf counter).

## Operation
- States: IDLE, BUSY, DONE. 5-bit step counter cnt.
- Multicycle op = mult/multu/div/divu (mult/multu only when fast multiply is compiled out).
- IDLE: start & !flush & multicycle -> latch magnitudes (|a|,|b| for signed ops, raw for unsigned), result signs, op; cnt=0; -> BUSY.
- IDLE: start & !flush & mthi -> hi<=src_a; mtlo -> lo<=src_a; stay IDLE.
- BUSY: one shift-add (mul) or restore-subtract (div) step per cycle; cnt increments; at cnt==31 step, sign-corrected result is written to {hi,lo} on that edge -> DONE.
- DONE: ignores start (same instruction still in EX); -> IDLE.
- Multiply: {hi,lo} = 64-bit product; signed result negated when sign(a)^sign(b).
- Divide: lo=quotient, hi=remainder; quotient sign = sign(a)^sign(b), remainder sign = sign(a).
- Divide by zero (signed or unsigned): lo=32'hFFFF_FFFF, hi=src_a; still takes full latency.
- Signed 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- flush in BUSY or DONE: -> IDLE next edge, hi/lo unchanged. flush in IDLE: start ignored.
- rst: state=IDLE, cnt=0, hi=0, lo=0; overrides flush and start.

## Timing
- stall = (IDLE & start & !flush & multicycle) | (BUSY & !flush).
- Cycle 0 = start cycle in IDLE. Multicycle ops: stall high cycles 0..32 (33 cycles), BUSY cycles 1..32, hi/lo valid from cycle 33 (DONE), stall low in DONE.
- mthi/mtlo: no stall; hi/lo updated at end of cycle 0, visible cycle 1.
- Back-to-back: new op can start in the cycle after DONE.
- hi/lo are registered; mfhi/mflo same-cycle forwarding is outside this block.
- busy high exactly during BUSY.

## Configuration
- MULDIV_FAST_MUL_EN defined: mult/multu not multicycle; 32x32 signed/unsigned product computed combinationally and written to {hi,lo} at end of cycle 0, no stall, no BUSY.
- Undefined: mult/multu use the 32-step iterative path, same 33-cycle stall as divide.
- Divide is always iterative.

## Test plan
- Reset mid-divide at cycle 10 -> next cycle stall=0, busy=0, hi=lo=0.
- divu 100/7 -> stall high 33 cycles, then lo=14, hi=2; div -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- mult 0xFFFF_FFFF*2 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFFE; multu same operands -> hi=1, lo=0xFFFF_FFFE; check 0-stall with MULDIV_FAST_MUL_EN, 33-cycle stall without.
- div 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0; divu 5/0 -> lo=0xFFFF_FFFF, hi=5.
- divu started with hi=lo=0x1234, flush at cycle 20 -> IDLE next cycle, stall=0, hi=lo=0x1234 unchanged.
- mthi 0xA5A5_A5A5 then mtlo 0x5A5A_5A5A back-to-back -> no stall; hi/lo updated one cycle after each; op=111 -> no change.
